// File: rtl/ipd_pwm_actuador_if.sv
`default_nettype none
// ============================================================================
// Module   : ipd_pwm_actuador_if
// Brief    : Bus between the IPD controller and the PWM actuator stage.
//            master = controller side, slave = actuator side.
// Revision : 1.0 - initial release
// ============================================================================
interface ipd_pwm_actuador_if #(
  parameter int DATA_W = 19,
  parameter int CNT_W  = 16
);
  logic                     u_valid;
  logic signed [DATA_W-1:0] u_in;
  logic                     sample_tick;
  logic                     pwm_out;
  logic                     dir_out;
  logic        [CNT_W-1:0]  duty_q;
  logic                     sat_flag;

  modport master (
    output u_valid, u_in,
    input  sample_tick, pwm_out, dir_out, duty_q, sat_flag
  );

  modport slave (
    input  u_valid, u_in,
    output sample_tick, pwm_out, dir_out, duty_q, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/ipd_pwm_actuador.sv
`default_nettype none
// ============================================================================
// Module   : ipd_pwm_actuador
// Brief    : Converts the signed IPD controller output into direction plus
//            saturated duty and drives a fixed-period PWM. Emits the sample
//            strobe that enables the controller once per PWM frame group.
//            Optional macro IPD_PWM_DEADTIME_EN inserts one all-low frame on
//            every direction reversal.
// Revision : 1.0 - initial release
// ============================================================================
module ipd_pwm_actuador #(
  parameter int DATA_W     = 19,
  parameter int FRAC_W     = 0,
  parameter int PERIOD     = 1000,
  parameter int CNT_W      = 16,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  ipd_pwm_actuador_if.slave bus
);

  localparam int               PDIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int               MAG_W       = (DATA_W > CNT_W) ? DATA_W : CNT_W;
  localparam logic [CNT_W-1:0] C_PERIOD    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(PERIOD - 1);
  localparam logic [PDIV_W-1:0] C_PDIV_LAST = PDIV_W'(SAMPLE_DIV - 1);
  localparam logic [DATA_W-1:0] C_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] C_MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PDIV_W-1:0]   pdiv_q, pdiv_d;
  logic [CNT_W-1:0]    shadow_duty_q, shadow_duty_d;
  logic                shadow_dir_q, shadow_dir_d;
  logic                shadow_sat_q, shadow_sat_d;
  logic [CNT_W-1:0]    duty_reg_q, duty_d;
  logic                dir_q, dir_d;
  logic                sat_q, sat_d;
  logic                pwm_q, pwm_d;
  logic                tick_q, tick_d;

  logic                w_wrap;
  logic                w_sign;
  logic [DATA_W-1:0]   w_abs;
  logic [DATA_W-1:0]   w_shifted;
  logic [MAG_W-1:0]    w_mag;
  logic                w_conv_sat;
  logic [CNT_W-1:0]    w_conv_duty;
  logic [CNT_W-1:0]    w_src_duty;
  logic                w_src_dir;
  logic                w_src_sat;
  logic                w_dir_chg;

  // Conversion, shadow capture, frame update and PWM compare for the next edge
  always_comb begin
    w_wrap = (cnt_q == C_LAST);
    cnt_d  = w_wrap ? '0 : cnt_q + CNT_W'(1);
    pdiv_d = pdiv_q;
    if (w_wrap) begin
      pdiv_d = (pdiv_q == C_PDIV_LAST) ? '0 : pdiv_q + PDIV_W'(1);
    end
    tick_d = w_wrap && (pdiv_q == C_PDIV_LAST);

    // Magnitude: the most negative code has no positive twin, clamp it
    w_sign = bus.u_in[DATA_W-1];
    if (!w_sign) begin
      w_abs = bus.u_in;
    end else if (bus.u_in == C_MOST_NEG) begin
      w_abs = C_MOST_POS;
    end else begin
      w_abs = ~bus.u_in + DATA_W'(1);
    end
    w_shifted   = w_abs >> FRAC_W;
    w_mag       = MAG_W'(w_shifted);
    w_conv_sat  = (w_mag > MAG_W'(PERIOD));
    w_conv_duty = w_conv_sat ? C_PERIOD : w_mag[CNT_W-1:0];

    shadow_duty_d = shadow_duty_q;
    shadow_dir_d  = shadow_dir_q;
    shadow_sat_d  = shadow_sat_q;
    if (bus.u_valid) begin
      shadow_duty_d = w_conv_duty;
      shadow_dir_d  = w_sign;
      shadow_sat_d  = w_conv_sat;
    end

    // A strobe on the wrap edge bypasses the shadow so the frame is not lost
    w_src_duty = bus.u_valid ? w_conv_duty : shadow_duty_q;
    w_src_dir  = bus.u_valid ? w_sign      : shadow_dir_q;
    w_src_sat  = bus.u_valid ? w_conv_sat  : shadow_sat_q;

`ifdef IPD_PWM_DEADTIME_EN
    w_dir_chg = (w_src_dir != dir_q);
`else
    w_dir_chg = 1'b0;
`endif

    state_d = state_q;
    duty_d  = (state_q == ST_DEAD) ? '0 : duty_reg_q;
    dir_d   = dir_q;
    sat_d   = sat_q;
    if (w_wrap) begin
      if (w_dir_chg) begin
        state_d = ST_DEAD;
        duty_d  = '0;
        dir_d   = w_src_dir;
        sat_d   = 1'b0;
      end else begin
        state_d = ST_RUN;
        duty_d  = w_src_duty;
        dir_d   = w_src_dir;
        sat_d   = w_src_sat;
      end
    end

    pwm_d = (cnt_d < duty_d);
  end

  // All state and registered outputs; reset wins over every other input
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      pdiv_q        <= '0;
      shadow_duty_q <= '0;
      shadow_dir_q  <= 1'b0;
      shadow_sat_q  <= 1'b0;
      duty_reg_q    <= '0;
      dir_q         <= 1'b0;
      sat_q         <= 1'b0;
      pwm_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pdiv_q        <= pdiv_d;
      shadow_duty_q <= shadow_duty_d;
      shadow_dir_q  <= shadow_dir_d;
      shadow_sat_q  <= shadow_sat_d;
      duty_reg_q    <= duty_d;
      dir_q         <= dir_d;
      sat_q         <= sat_d;
      pwm_q         <= pwm_d;
      tick_q        <= tick_d;
    end
  end

  assign bus.sample_tick = tick_q;
  assign bus.pwm_out     = pwm_q;
  assign bus.dir_out     = dir_q;
  assign bus.duty_q      = duty_reg_q;
  assign bus.sat_flag    = sat_q;

endmodule
`default_nettype wire
